uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo_mem.sv | 32 +++
 rtl/uart_rx_fifo.sv | 102 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, transmitter and RX FIFO.
// Latency: none (constants and a constant function only).
// Backpressure: not applicable.
package uart_pkg;

  // Default width of one UART word.
  localparam int UART_PAYLOAD_BITS = 8;

  // Default RX FIFO entry count (power of two).
  localparam int UART_FIFO_DEPTH = 16;

  // Pointer width for a FIFO of the given depth: one extra bit tells full from empty.
  function automatic int uart_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Address width into the storage array for a FIFO of the given depth.
  function automatic int uart_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART RX FIFO: Depth x PayloadBits, not reset.
// Latency: write lands on the clock edge, read is combinational from the address.
// Backpressure: none; the caller decides when a write is allowed.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int Param_PayloadBits = UART_PAYLOAD_BITS,
  parameter int Param_Depth       = UART_FIFO_DEPTH
) (
  input  logic                                 IO_Clk_I,
  input  logic                                 wr_vld,
  input  logic [uart_addr_w(Param_Depth)-1:0]  wr_addr,
  input  logic [Param_PayloadBits-1:0]         wr_dat,
  input  logic [uart_addr_w(Param_Depth)-1:0]  rd_addr,
  output logic [Param_PayloadBits-1:0]         rd_dat
);

  logic [Param_PayloadBits-1:0] mem [Param_Depth];

  // Synchronous write of one entry; contents survive reset by design.
  always_ff @(posedge IO_Clk_I) begin
    if (wr_vld) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Asynchronous read gives first-word-fall-through at the FIFO level.
  always_comb begin
    rd_dat = mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and its consumer, with overrun and IRQ.
// Latency: a pushed word is visible on IO_RdData_O one cycle after the push edge.
// Backpressure: none toward the receiver; words arriving while full are dropped and flagged.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int Param_PayloadBits  = UART_PAYLOAD_BITS,
  parameter int Param_Depth        = UART_FIFO_DEPTH,
  parameter int Param_IrqThreshold = 1
) (
  input  logic                                IO_Clk_I,
  input  logic                                IO_Rst_I,
  input  logic                                IO_RxDone_I,
  input  logic [Param_PayloadBits-1:0]        IO_RxData_I,
  output logic                                IO_RdValid_O,
  output logic [Param_PayloadBits-1:0]        IO_RdData_O,
  input  logic                                IO_RdReady_I,
  output logic [uart_ptr_w(Param_Depth)-1:0]  IO_Count_O,
  output logic                                IO_Full_O,
  output logic                                IO_Empty_O,
  output logic                                IO_Overrun_O,
  input  logic                                IO_OverrunClr_I,
  input  logic                                IO_Flush_I,
  output logic                                IO_Irq_O
);

  localparam int PtrW  = uart_ptr_w(Param_Depth);
  localparam int AddrW = uart_addr_w(Param_Depth);

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] count;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            overrun_set;
  logic            overrun;

  // Occupancy and flags come straight from the pointers; the modulo-2*Depth wrap
  // makes the truncated difference exact for every level 0..Depth.
  always_comb begin
    count       = wr_ptr - rd_ptr;
    full        = (count == PtrW'(Param_Depth));
    empty       = (count == '0);
    pop         = ~empty & IO_RdReady_I & ~IO_Flush_I;
    push        = IO_RxDone_I & ~IO_Flush_I & (~full | pop);
    overrun_set = IO_RxDone_I & ~IO_Flush_I & full & ~pop;
  end

  // Pointer update: reset beats flush, flush beats push/pop.
  always_ff @(posedge IO_Clk_I) begin
    if (IO_Rst_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (IO_Flush_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky overrun: a new drop wins over a clear in the same cycle.
  always_ff @(posedge IO_Clk_I) begin
    if (IO_Rst_I) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (IO_OverrunClr_I) begin
      overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .Param_PayloadBits (Param_PayloadBits),
    .Param_Depth       (Param_Depth)
  ) u_mem (
    .IO_Clk_I (IO_Clk_I),
    .wr_vld   (push & ~IO_Rst_I),
    .wr_addr  (wr_ptr[AddrW-1:0]),
    .wr_dat   (IO_RxData_I),
    .rd_addr  (rd_ptr[AddrW-1:0]),
    .rd_dat   (IO_RdData_O)
  );

  // Outputs derive only from registered pointers and the overrun register.
  always_comb begin
    IO_RdValid_O = ~empty;
    IO_Count_O   = count;
    IO_Full_O    = full;
    IO_Empty_O   = empty;
    IO_Overrun_O = overrun;
    IO_Irq_O     = (count >= PtrW'(Param_IrqThreshold)) | overrun;
  end

endmodule
